// File: rtl/operand_sequencer.sv
// Serial operand loader for the 4-operand add/sub stage: collects A..D one nibble at a time,
// waits EVAL_CYCLES, captures F. Optional overflow flag under SEQ_OVF_FLAG_EN.
module operand_sequencer #(
    parameter int EVAL_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] nib_in,
    input  logic       nib_valid,
    output logic       nib_ready,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] C,
    output logic [3:0] D,
    input  logic [4:0] F_in,
    output logic [4:0] res_out,
    output logic       res_valid,
    input  logic       res_ready
`ifdef SEQ_OVF_FLAG_EN
    ,
    output logic       ovf
`endif
);

    typedef enum logic [1:0] {LOAD, EVAL, HOLD} state_t;

    localparam logic [3:0] CNT_INIT = 4'(EVAL_CYCLES - 1);

    state_t     state, state_nx;
    logic [1:0] idx;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;
    logic       release_res;

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        nib_ready   = 1'b0;
        capture     = 1'b0;
        release_res = 1'b0;
        case (state)
            LOAD: begin
                nib_ready = 1'b1;
                if (nib_valid && idx == 2'd3) state_nx = EVAL;
            end
            EVAL: begin
                if (cnt == 4'd0) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    release_res = 1'b1;
                    state_nx    = LOAD;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    assign accept = nib_valid & nib_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= 2'd0;
            cnt       <= 4'd0;
            A         <= 4'd0;
            B         <= 4'd0;
            C         <= 4'd0;
            D         <= 4'd0;
            res_out   <= 5'd0;
            res_valid <= 1'b0;
        end else begin
            if (accept) begin
                case (idx)
                    2'd0: A <= nib_in;
                    2'd1: B <= nib_in;
                    2'd2: C <= nib_in;
                    2'd3: D <= nib_in;
                    default: ;
                endcase
                // 2-bit index wraps to 0 on its own after D
                idx <= idx + 2'd1;
            end
            if (accept && idx == 2'd3) cnt <= CNT_INIT;
            else if (state == EVAL && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (capture) begin
                res_out   <= F_in;
                res_valid <= 1'b1;
            end else if (release_res) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef SEQ_OVF_FLAG_EN
    // Exact signed result from our own operands; range -30..30 fits in 7 bits
    logic signed [6:0] exact;
    assign exact = $signed({3'b000, A}) + $signed({3'b000, B})
                 - $signed({3'b000, C}) - $signed({3'b000, D});

    always_ff @(posedge clk) begin
        if (rst)              ovf <= 1'b0;
        else if (capture)     ovf <= (exact > 7'sd15) || (exact < -7'sd16);
        else if (release_res) ovf <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed bench for operand_sequencer: EVAL_CYCLES=1 instance for the main flow and an
// EVAL_CYCLES=3 instance for the settle-delay case; both wired to a model of the add/sub stage.
module tb_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] nib_in, nib_in3;
    logic       nib_valid, nib_valid3;
    logic       nib_ready, nib_ready3;
    logic [3:0] opa, opb, opc, opd, opa3, opb3, opc3, opd3;
    logic [4:0] f, f3;
    logic [4:0] res_out, res_out3;
    logic       res_valid, res_valid3;
    logic       res_ready, res_ready3;
`ifdef SEQ_OVF_FLAG_EN
    logic       ovf, ovf3;
`endif

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Combinational add/sub stage, result modulo 32
    assign f  = {1'b0, opa} + {1'b0, opb} - {1'b0, opc} - {1'b0, opd};
    assign f3 = {1'b0, opa3} + {1'b0, opb3} - {1'b0, opc3} - {1'b0, opd3};

    operand_sequencer #(.EVAL_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .nib_in(nib_in), .nib_valid(nib_valid), .nib_ready(nib_ready),
        .A(opa), .B(opb), .C(opc), .D(opd), .F_in(f),
        .res_out(res_out), .res_valid(res_valid), .res_ready(res_ready)
`ifdef SEQ_OVF_FLAG_EN
        , .ovf(ovf)
`endif
    );

    operand_sequencer #(.EVAL_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .nib_in(nib_in3), .nib_valid(nib_valid3), .nib_ready(nib_ready3),
        .A(opa3), .B(opb3), .C(opc3), .D(opd3), .F_in(f3),
        .res_out(res_out3), .res_valid(res_valid3), .res_ready(res_ready3)
`ifdef SEQ_OVF_FLAG_EN
        , .ovf(ovf3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Four consecutive accepts; returns just after the 4th accept edge
    task automatic load4(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] c, input logic [3:0] d);
        nib_valid = 1'b1;
        nib_in = a; tick();
        nib_in = b; tick();
        nib_in = c; tick();
        nib_in = d; tick();
        nib_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; nib_in = 4'd0; nib_valid = 1'b0; res_ready = 1'b1;
        nib_in3 = 4'd0; nib_valid3 = 1'b0; res_ready3 = 1'b1;
        tick(); tick();
        chk("rst_A", {4'd0, opa}, 8'd0);
        chk("rst_D", {4'd0, opd}, 8'd0);
        chk("rst_res_out", {3'd0, res_out}, 8'd0);
        chk("rst_res_valid", {7'd0, res_valid}, 8'd0);
`ifdef SEQ_OVF_FLAG_EN
        chk("rst_ovf", {7'd0, ovf}, 8'd0);
`endif
        rst = 1'b0;
        tick();
        chk("ready_after_rst", {7'd0, nib_ready}, 8'd1);

        // Basic load 11,12,9,7 -> 7
        load4(4'd11, 4'd12, 4'd9, 4'd7);
        chk("basic_ready_lo1", {7'd0, nib_ready}, 8'd0);
        chk("basic_valid_k", {7'd0, res_valid}, 8'd0);
        chk("basic_B", {4'd0, opb}, 8'd12);
        tick();
        chk("basic_ready_lo2", {7'd0, nib_ready}, 8'd0);
        chk("basic_valid", {7'd0, res_valid}, 8'd1);
        chk("basic_res", {3'd0, res_out}, 8'd7);
`ifdef SEQ_OVF_FLAG_EN
        chk("basic_ovf", {7'd0, ovf}, 8'd0);
`endif
        tick();
        chk("basic_ready_back", {7'd0, nib_ready}, 8'd1);
        chk("basic_valid_clr", {7'd0, res_valid}, 8'd0);

        // Back-to-back sets, 6 cycles each
        load4(4'd14, 4'd14, 4'd13, 4'd11); tick();
        chk("b2b_res0", {3'd0, res_out}, 8'd4);
        chk("b2b_val0", {7'd0, res_valid}, 8'd1);
        tick();
        load4(4'd14, 4'd8, 4'd0, 4'd8); tick();
        chk("b2b_res1", {3'd0, res_out}, 8'd14);
        chk("b2b_val1", {7'd0, res_valid}, 8'd1);
        tick();
        load4(4'd5, 4'd14, 4'd1, 4'd3); tick();
        chk("b2b_res2", {3'd0, res_out}, 8'd15);
        chk("b2b_val2", {7'd0, res_valid}, 8'd1);
        tick();
        chk("b2b_ready", {7'd0, nib_ready}, 8'd1);

        // HOLD with backpressure; nibbles offered during HOLD must be ignored
        res_ready = 1'b0;
        load4(4'd15, 4'd15, 4'd9, 4'd11); tick();
        for (int i = 0; i < 5; i++) begin
            nib_in = 4'd3; nib_valid = (i % 2 == 0);
            tick();
            chk("hold_valid", {7'd0, res_valid}, 8'd1);
            chk("hold_res", {3'd0, res_out}, 8'd10);
            chk("hold_ready", {7'd0, nib_ready}, 8'd0);
        end
        nib_valid = 1'b0;
        chk("hold_A", {4'd0, opa}, 8'd15);
        chk("hold_B", {4'd0, opb}, 8'd15);
        chk("hold_C", {4'd0, opc}, 8'd9);
        chk("hold_D", {4'd0, opd}, 8'd11);
        res_ready = 1'b1;
        tick();
        chk("hold_release", {7'd0, res_valid}, 8'd0);
        chk("hold_ready_back", {7'd0, nib_ready}, 8'd1);

`ifdef SEQ_OVF_FLAG_EN
        load4(4'd15, 4'd15, 4'd0, 4'd0); tick();
        chk("ovf_pos_res", {3'd0, res_out}, 8'd30);
        chk("ovf_pos", {7'd0, ovf}, 8'd1);
        tick();
        chk("ovf_clr", {7'd0, ovf}, 8'd0);
        load4(4'd0, 4'd0, 4'd15, 4'd15); tick();
        chk("ovf_neg_res", {3'd0, res_out}, 8'd2);
        chk("ovf_neg", {7'd0, ovf}, 8'd1);
        tick();
`endif

        // Reset after a partial load of two nibbles
        nib_valid = 1'b1;
        nib_in = 4'd5; tick();
        nib_in = 4'd6; tick();
        nib_valid = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_A", {4'd0, opa}, 8'd0);
        chk("mrst_B", {4'd0, opb}, 8'd0);
        chk("mrst_res", {3'd0, res_out}, 8'd0);
        chk("mrst_valid", {7'd0, res_valid}, 8'd0);
        load4(4'd11, 4'd12, 4'd9, 4'd7); tick();
        chk("mrst_A_after", {4'd0, opa}, 8'd11);
        chk("mrst_res_after", {3'd0, res_out}, 8'd7);
        chk("mrst_valid_after", {7'd0, res_valid}, 8'd1);
        tick();

        // EVAL_CYCLES=3, gapped load 9,8,-,3,2 -> 12 three cycles after 4th accept
        nib_valid3 = 1'b1;
        nib_in3 = 4'd9; tick();
        nib_in3 = 4'd8; tick();
        nib_valid3 = 1'b0; tick();
        chk("e3_gap_ready", {7'd0, nib_ready3}, 8'd1);
        nib_valid3 = 1'b1;
        nib_in3 = 4'd3; tick();
        nib_in3 = 4'd2; tick();
        nib_valid3 = 1'b0;
        chk("e3_valid_k0", {7'd0, res_valid3}, 8'd0);
        tick();
        chk("e3_valid_k1", {7'd0, res_valid3}, 8'd0);
        tick();
        chk("e3_valid_k2", {7'd0, res_valid3}, 8'd0);
        tick();
        chk("e3_valid_k3", {7'd0, res_valid3}, 8'd1);
        chk("e3_res", {3'd0, res_out3}, 8'd12);
        tick();
        chk("e3_release", {7'd0, res_valid3}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
